move_scheduler: RTL
===================

# move_scheduler

Sequences one 2048 move across the board datapath. Converts synchronized button levels into single move requests and arbitrates simultaneous presses. Drives the row/column slide engine one lane at a time, then requests a random-tile spawn only if some lane changed. Sits between the button synchronizers and the board/slide/spawn datapath in `TwentyFortyEight`.

## Interface
Parameters:
- `LANE_TIMEOUT`, 64: maximum cycles to wait for `lane_done` after `lane_start`. Legal range is 2..255.
- `CNT_W`, 16: width of `move_count`.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-low
- `btn_s`, `btn_u`, `btn_d`, `btn_l`, `btn_r`  in  1 each  synchronized button levels
- `game_over`  in  1  level from board; blocks direction moves
- `lane_start`  out  1  one-cycle pulse: process lane `lane_idx`
- `lane_idx`  out  2  lane under process, 0..3
- `lane_dir`  out  2  0=up, 1=down, 2=left, 3=right
- `lane_done`  in  1  slide engine finished current lane (one-cycle pulse)
- `lane_moved`  in  1  qualified by `lane_done`: lane content changed
- `spawn_req`  out  1  request new tile, held until ack
- `spawn_ack`  in  1  spawn complete
- `clear_req`  out  1  one-cycle pulse: clear board (new game)
- `busy`  out  1  state ≠ IDLE
- `err_timeout`  out  1  one-cycle pulse on lane timeout
- `move_count`  out  `CNT_W`  completed effective moves, wraps

## Operation
- Edge detect: each button has a registered copy. A press is a `btn & ~btn_q` seen at a clock edge. `btn_q` updates every cycle in all states.
- Arbitration for presses at the same edge: S > U > D > L > R. Only the winner is used.
- A direction press is ignored while `game_over`=1. `btn_s` is always accepted.
- States: IDLE, ISSUE, WAIT, SPAWN, CLEAR.
- IDLE:
  - Accepted S press → CLEAR.
  - Accepted direction → ISSUE, with `lane_idx`=0, `lane_dir` latched, moved flag cleared.
- ISSUE: `lane_start`=1 for exactly this cycle. Clear the timeout counter, then → WAIT.
- WAIT, on `lane_done`:
  - OR `lane_moved` into the moved flag.
  - If `lane_idx`≠3: `lane_idx`+1, → ISSUE.
  - If `lane_idx`=3: → SPAWN if the updated moved flag is 1, otherwise → IDLE (no spawn, no count).
- WAIT timeout: the counter reaches `LANE_TIMEOUT` with no `lane_done` → `err_timeout` pulse, → IDLE. The move is abandoned and `move_count` is unchanged.
- SPAWN: `spawn_req`=1 until the cycle `spawn_ack`=1. Then → IDLE with `move_count`+1 (wraps). `spawn_ack` outside SPAWN is ignored.
- CLEAR: `clear_req`=1 for one cycle, `move_count`←0, → IDLE.
- Presses while `busy`: see Configuration.
- `btn_s` while busy is never preempting. It follows the same busy-press rule as directions.
- `lane_done` outside WAIT is ignored.

## Timing
- Reset values: state IDLE, all `btn_q`=0, `lane_start`=0, `lane_idx`=0, `lane_dir`=0, `spawn_req`=0, `clear_req`=0, `busy`=0, `err_timeout`=0, `move_count`=0. Internal moved flag=0, queue empty.
- Reset mid-move returns to IDLE immediately. No pulse is completed.
- Press sampled at edge N → ISSUE (and `lane_start`) in cycle N+1.
- `lane_done` at edge M → next `lane_start` in cycle M+1.
- Minimum move with a 1-cycle engine and immediate ack: 4×2 + 1 cycles from first `lane_start` to return to IDLE.
- All outputs are registered or decoded from state only. None has a combinational path from inputs.
- Outputs change only on clock edges, except on asynchronous reset.

## Configuration
- `MOVE_QUEUE_EN` defined:
  - A one-entry queue captures the first arbitrated press accepted while busy. Later presses while the queue is full are dropped.
  - On return to IDLE, a queued press is launched as if pressed at that edge: → ISSUE or CLEAR the next cycle.
  - A queued direction is discarded if `game_over`=1 at launch.
  - The queue is cleared by reset and by CLEAR.
- Undefined: all presses while busy are dropped.

## Test plan
- Reset: hold `rst`=0 with buttons high → all outputs 0. Release; buttons still high → no move (no rising edge).
- Move down: `btn_d` rises, engine returns `lane_done` 3 cycles after each start with `lane_moved`=1 only on lane 2 → four `lane_start` with `lane_idx` 0,1,2,3 and `lane_dir`=1; one `spawn_req`; ack → `move_count`=1.
- No-op move: `btn_l` with `lane_moved`=0 on all lanes → no `spawn_req`, `move_count` unchanged, back to IDLE.
- Priority: `btn_u`, `btn_r` and `btn_s` rise on the same edge → CLEAR only, `clear_req` one cycle, `move_count`=0. Then `btn_u` and `btn_r` rise together → `lane_dir`=0.
- Timeout: `LANE_TIMEOUT`=8, withhold `lane_done` on lane 1 → `err_timeout` pulse, IDLE, no spawn. `game_over`=1 then `btn_d` → no `lane_start`.
- Queue (`MOVE_QUEUE_EN`): `btn_r` then `btn_l` rise during a move → right move completes, then left move starts the cycle after IDLE. A further `btn_u` press during that window is dropped. Without the macro, the left press is dropped.

Source files
------------

// File: rtl/move_scheduler.sv
// -----------------------------------------------------------------------------
// move_scheduler
//
// Turns synchronized button levels into single 2048 move requests, then walks
// the slide engine across the four lanes of the board one lane at a time.
// After the last lane, a tile spawn is requested only if at least one lane
// changed. A start press clears the board and the move counter.
//
// Simultaneous presses at one edge are arbitrated S > U > D > L > R. Direction
// presses are ignored while game_over is high. The start button is always
// accepted.
//
// Build option: define MOVE_QUEUE_EN to add a one-entry queue. It holds the
// first press seen while busy and launches it when the FSM returns to IDLE.
// Without the macro, presses made while busy are dropped.
//
// Ports
//   clk, rst         clock; asynchronous active-low reset
//   btn_s/u/d/l/r    synchronized button levels (start, up, down, left, right)
//   game_over        board level; blocks direction moves
//   lane_start       one-cycle pulse: slide lane lane_idx in direction lane_dir
//   lane_idx         lane under process, 0..3
//   lane_dir         0=up, 1=down, 2=left, 3=right
//   lane_done        slide engine finished the current lane (pulse)
//   lane_moved       qualified by lane_done: lane content changed
//   spawn_req        request a new tile; held until spawn_ack
//   spawn_ack        spawn complete
//   clear_req        one-cycle pulse: clear the board (new game)
//   busy             FSM is not IDLE
//   err_timeout      one-cycle pulse when a lane never reports done
//   move_count       effective moves completed; wraps
//   dbg_state        FSM state: 0 IDLE, 1 ISSUE, 2 WAIT, 3 SPAWN, 4 CLEAR
//
// Handshakes: lane_start/lane_done form a request/response pair. Exactly one
// lane_done is expected per lane_start. A lane_done outside WAIT is ignored.
// spawn_req stays high until the cycle in which spawn_ack is seen high. A
// spawn_ack outside SPAWN is ignored.
// -----------------------------------------------------------------------------
module move_scheduler #(
    parameter int LANE_TIMEOUT = 64,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_s,
    input  logic             btn_u,
    input  logic             btn_d,
    input  logic             btn_l,
    input  logic             btn_r,
    input  logic             game_over,
    output logic             lane_start,
    output logic [1:0]       lane_idx,
    output logic [1:0]       lane_dir,
    input  logic             lane_done,
    input  logic             lane_moved,
    output logic             spawn_req,
    input  logic             spawn_ack,
    output logic             clear_req,
    output logic             busy,
    output logic             err_timeout,
    output logic [CNT_W-1:0] move_count,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_SPAWN = 3'd3,
        S_CLEAR = 3'd4
    } state_t;

    // The lane timeout fires on the LANE_TIMEOUT-th WAIT cycle without lane_done.
    localparam logic [7:0] TMO_LAST = 8'(LANE_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [4:0]       btn_q;
    logic             armed_q;
    logic [1:0]       lane_idx_q, lane_idx_d;
    logic [1:0]       lane_dir_q, lane_dir_d;
    logic             moved_q, moved_d;
    logic [7:0]       tmo_cnt_q, tmo_cnt_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [4:0]       btn_now;
    logic [4:0]       rise;
    logic             press_vld;
    logic             press_is_s;
    logic [1:0]       press_dir;
    logic             go_vld;
    logic             go_is_s;
    logic [1:0]       go_dir;
    logic             moved_upd;

    // Bit order: 4=S, 3=U, 2=D, 1=L, 0=R (descending priority).
    assign btn_now = {btn_s, btn_u, btn_d, btn_l, btn_r};

    // armed_q masks the first edge after reset. Buttons already held through
    // reset then do not look like fresh presses.
    assign rise       = armed_q ? (btn_now & ~btn_q) : 5'd0;
    assign press_vld  = |rise;
    assign press_is_s = rise[4];

    always_comb begin
        press_dir = 2'd3;
        if (rise[3]) begin
            press_dir = 2'd0;
        end else if (rise[2]) begin
            press_dir = 2'd1;
        end else if (rise[1]) begin
            press_dir = 2'd2;
        end
    end

`ifdef MOVE_QUEUE_EN
    logic       q_valid_q, q_valid_d;
    logic       q_is_s_q, q_is_s_d;
    logic [1:0] q_dir_q, q_dir_d;

    // A queued press launches before a fresh press at the same IDLE edge. A
    // queued direction that is blocked by game_over is discarded. A fresh
    // press can still launch on that edge.
    always_comb begin
        go_vld  = 1'b0;
        go_is_s = 1'b0;
        go_dir  = 2'd0;
        if (q_valid_q && (q_is_s_q || !game_over)) begin
            go_vld  = 1'b1;
            go_is_s = q_is_s_q;
            go_dir  = q_dir_q;
        end else if (press_vld && (press_is_s || !game_over)) begin
            go_vld  = 1'b1;
            go_is_s = press_is_s;
            go_dir  = press_dir;
        end
    end

    // IDLE always empties the queue: the entry either launched or was discarded.
    always_comb begin
        q_valid_d = q_valid_q;
        q_is_s_d  = q_is_s_q;
        q_dir_d   = q_dir_q;
        if (state_q == S_IDLE || state_q == S_CLEAR) begin
            q_valid_d = 1'b0;
        end else if (!q_valid_q && press_vld) begin
            q_valid_d = 1'b1;
            q_is_s_d  = press_is_s;
            q_dir_d   = press_dir;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_valid_q <= 1'b0;
            q_is_s_q  <= 1'b0;
            q_dir_q   <= 2'd0;
        end else begin
            q_valid_q <= q_valid_d;
            q_is_s_q  <= q_is_s_d;
            q_dir_q   <= q_dir_d;
        end
    end
`else
    always_comb begin
        go_vld  = 1'b0;
        go_is_s = 1'b0;
        go_dir  = 2'd0;
        if (press_vld && (press_is_s || !game_over)) begin
            go_vld  = 1'b1;
            go_is_s = press_is_s;
            go_dir  = press_dir;
        end
    end
`endif

    assign moved_upd = moved_q | lane_moved;

    always_comb begin
        state_d    = state_q;
        lane_idx_d = lane_idx_q;
        lane_dir_d = lane_dir_q;
        moved_d    = moved_q;
        tmo_cnt_d  = tmo_cnt_q;
        err_d      = 1'b0;
        count_d    = count_q;
        case (state_q)
            S_IDLE: begin
                if (go_vld) begin
                    if (go_is_s) begin
                        state_d = S_CLEAR;
                    end else begin
                        state_d    = S_ISSUE;
                        lane_idx_d = 2'd0;
                        lane_dir_d = go_dir;
                        moved_d    = 1'b0;
                    end
                end
            end
            S_ISSUE: begin
                tmo_cnt_d = 8'd0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (lane_done) begin
                    moved_d = moved_upd;
                    if (lane_idx_q != 2'd3) begin
                        lane_idx_d = lane_idx_q + 2'd1;
                        state_d    = S_ISSUE;
                    end else begin
                        state_d = moved_upd ? S_SPAWN : S_IDLE;
                    end
                end else if (tmo_cnt_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            S_SPAWN: begin
                if (spawn_ack) begin
                    count_d = count_q + CNT_W'(1);
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                count_d = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            btn_q      <= 5'd0;
            armed_q    <= 1'b0;
            lane_idx_q <= 2'd0;
            lane_dir_q <= 2'd0;
            moved_q    <= 1'b0;
            tmo_cnt_q  <= 8'd0;
            err_q      <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            btn_q      <= btn_now;
            armed_q    <= 1'b1;
            lane_idx_q <= lane_idx_d;
            lane_dir_q <= lane_dir_d;
            moved_q    <= moved_d;
            tmo_cnt_q  <= tmo_cnt_d;
            err_q      <= err_d;
            count_q    <= count_d;
        end
    end

    assign lane_start  = (state_q == S_ISSUE);
    assign spawn_req   = (state_q == S_SPAWN);
    assign clear_req   = (state_q == S_CLEAR);
    assign busy        = (state_q != S_IDLE);
    assign lane_idx    = lane_idx_q;
    assign lane_dir    = lane_dir_q;
    assign err_timeout = err_q;
    assign move_count  = count_q;
    assign dbg_state   = state_q;

endmodule
